exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute stage directly downstream of the register file; consumes the two read operands and an opcode.
- Single-cycle ALU ops plus iterative MUL/DIV/MOD for the modular-arithmetic datapath.
- Produces a one-cycle write-back (`writeEn`, `dest`, `writeVal`) into the register file's write port, plus status flags.

Parameters:
- REG_ADDR, 3, register address width
- REG_SIZE, 16, operand/result width; iterative ops take REG_SIZE cycles
- OP_WIDTH, 4, opcode width

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous active-low reset (0 = reset)
- start  input  1  issue request; sampled only in IDLE
- opcode  input  OP_WIDTH  operation select
- destIn  input  REG_ADDR  destination register for result
- opA  input  REG_SIZE  operand A (register-file reg1)
- opB  input  REG_SIZE  operand B (register-file reg2)
- busy  output  1  high whenever state != IDLE
- writeEn  output  1  one-cycle write-back strobe
- dest  output  REG_ADDR  write-back address
- writeVal  output  REG_SIZE  write-back data
- carry  output  1  ADD carry-out / SUB borrow / MUL overflow
- zero  output  1  result == 0
- divZero  output  1  DIV/MOD with opB == 0
- illegal  output  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - All outputs and internal registers go to 0.
  - Any in-flight op is discarded; no write-back ever occurs for it.
- FSM states:
  - IDLE: on `start`, latch opA, opB, opcode, destIn.
    - Single-cycle op -> WB.
    - MUL, or DIV/MOD with opB != 0 -> ITER; counter = 0.
    - DIV/MOD with opB == 0 -> WB.
    - Opcode 11-15 -> IDLE, `illegal` = 1 for one cycle, no write-back, flags unchanged.
  - ITER: one shift-add (MUL) or restoring-division step (DIV/MOD) per cycle. When counter == REG_SIZE-1 -> WB.
  - WB: `writeEn` = 1 for exactly one cycle; `dest` = latched destIn; `writeVal` = result; flags updated. Next state IDLE.
- Latency, with start sampled at edge N:
  - Single-cycle op: `writeEn` high between edges N+1 and N+2 (registered, so stable across that negedge write).
  - Iterative op: `writeEn` high between edges N+17 and N+18.
  - `busy` high for 1 cycle (single-cycle op) or 17 cycles (iterative op).
- `start` while busy is ignored; the in-flight op is unaffected.
- Opcodes:
  - 0 ADD
  - 1 SUB (A-B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL A by B[3:0]
  - 6 SHR (logical) A by B[3:0]
  - 7 MOV (result = B)
  - 8 MUL
  - 9 DIV (quotient)
  - 10 MOD (remainder)
- Width rules:
  - ADD/SUB are computed at REG_SIZE+1 bits; the extra bit drives `carry` (borrow on SUB).
  - MUL uses a 2*REG_SIZE accumulator; `writeVal` = low half; `carry` = (high half != 0).
  - `carry` = 0 for all other ops.
- Divide-by-zero:
  - DIV returns all-ones; MOD returns opA.
  - `divZero` = 1; otherwise `divZero` = 0. Updated in WB.
- Flag timing: `zero`, `carry` and `divZero` update only in WB and hold until the next WB.
- `writeVal` and `dest` hold their last value outside WB.

Decomposition:
- Shared defines file holds:
  - Opcode constants (OP_ADD..OP_MOD)
  - State encodings (ST_IDLE, ST_ITER, ST_WB)
  - REG_SIZE/REG_ADDR defaults, shared with the register file
- One natural sub-module: `iter_muldiv`.
  - Contains the shared shift register/accumulator, the iteration counter and the restoring-division subtractor.
  - Interface: go, mode, a, b, done, lo, hi.
  - `exec_unit` keeps the FSM, the single-cycle ALU and write-back.

Test Plan:
- ADD opA=0xFFFF, opB=0x0001, destIn=3 -> `writeEn` pulse one cycle after issue, `dest`=3, `writeVal`=0x0000, `carry`=1, `zero`=1, `busy` high 1 cycle.
- MUL 0x0123*0x0010 -> `writeVal`=0x1230, `carry`=0, `writeEn` at N+17, `busy` 17 cycles; then MUL 0x8000*0x0002 -> `writeVal`=0x0000, `carry`=1, `zero`=1.
- DIV 0x03E8/0x0007 -> 0x008E; MOD 0xBEEF mod 0x0100 -> 0x00EF; `divZero`=0, 17-cycle latency each.
- MOD opA=0x1234, opB=0 -> `writeVal`=0x1234, `divZero`=1, single-cycle latency; DIV opB=0 -> `writeVal`=0xFFFF.
- Start held high during a MUL with different operands -> ignored, exactly one write-back; opcode 0xC -> `illegal` pulse 1 cycle, no `writeEn`, flags unchanged.
- Assert rst=0 at ITER cycle 8 of a MUL -> all outputs 0 immediately, no `writeEn` after release; a subsequent SUB 5-7 -> `writeVal`=0xFFFE, `carry`=1.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute stage: widths (also used by the
// register file), opcode values, FSM state encodings and a decode helper.
package exec_unit_pkg;

    localparam int REG_ADDR = 3;
    localparam int REG_SIZE = 16;
    localparam int OP_WIDTH = 4;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MOV = 4'd7,
        OP_MUL = 4'd8,
        OP_DIV = 4'd9,
        OP_MOD = 4'd10
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // MUL always iterates; DIV/MOD iterate only with a non-zero divisor,
    // otherwise their fixed divide-by-zero result is written back directly.
    function automatic logic is_iterative(input logic [OP_WIDTH-1:0] op,
                                          input logic [REG_SIZE-1:0] b);
        return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != '0));
    endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Issue/write-back bundle between the register file side and the execute stage.
interface exec_unit_if;
    import exec_unit_pkg::*;

    logic                start;
    logic [OP_WIDTH-1:0] opcode;
    logic [REG_ADDR-1:0] destIn;
    logic [REG_SIZE-1:0] opA;
    logic [REG_SIZE-1:0] opB;
    logic                busy;
    logic                writeEn;
    logic [REG_ADDR-1:0] dest;
    logic [REG_SIZE-1:0] writeVal;
    logic                carry;
    logic                zero;
    logic                divZero;
    logic                illegal;

    modport master (
        output start, opcode, destIn, opA, opB,
        input  busy, writeEn, dest, writeVal, carry, zero, divZero, illegal
    );

    modport slave (
        input  start, opcode, destIn, opA, opB,
        output busy, writeEn, dest, writeVal, carry, zero, divZero, illegal
    );
endinterface

// File: rtl/exec_unit_iter_muldiv.sv
// Iterative multiplier / restoring divider sharing one {hi, lo} register pair.
// MUL: {hi, lo} ends as the full product. DIV: lo = quotient, hi = remainder.
module iter_muldiv
    import exec_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                mode,   // 0 = multiply, 1 = divide
    input  logic [REG_SIZE-1:0] a,
    input  logic [REG_SIZE-1:0] b,
    output logic                done,
    output logic [REG_SIZE-1:0] lo,
    output logic [REG_SIZE-1:0] hi
);
    localparam int CW = $clog2(REG_SIZE);
    localparam logic [CW-1:0] LAST = CW'(REG_SIZE - 1);

    logic [REG_SIZE-1:0] lo_reg, hi_reg, b_reg;
    logic [CW-1:0]       count_reg;
    logic                run_reg, mode_reg;

    logic [REG_SIZE:0]   mul_sum;
    logic [REG_SIZE:0]   div_shift;
    logic [REG_SIZE-1:0] div_rem;
    logic                div_fits;

    // Shift-add step: add the multiplicand when the multiplier LSB is set,
    // then shift the whole accumulator right one place.
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor only if it fits.
    assign div_shift = {hi_reg, lo_reg[REG_SIZE-1]};
    assign div_fits  = (div_shift >= {1'b0, b_reg});
    assign div_rem   = div_shift[REG_SIZE-1:0] - b_reg;

    assign done = run_reg && (count_reg == LAST);
    assign lo   = lo_reg;
    assign hi   = hi_reg;

    // Load operands on go, then perform one step per cycle for REG_SIZE cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_reg    <= '0;
            hi_reg    <= '0;
            b_reg     <= '0;
            count_reg <= '0;
            run_reg   <= 1'b0;
            mode_reg  <= 1'b0;
        end else if (go) begin
            lo_reg    <= a;
            hi_reg    <= '0;
            b_reg     <= b;
            count_reg <= '0;
            run_reg   <= 1'b1;
            mode_reg  <= mode;
        end else if (run_reg) begin
            if (mode_reg) begin
                hi_reg <= div_fits ? div_rem : div_shift[REG_SIZE-1:0];
                lo_reg <= {lo_reg[REG_SIZE-2:0], div_fits};
            end else begin
                hi_reg <= mul_sum[REG_SIZE:1];
                lo_reg <= {mul_sum[0], lo_reg[REG_SIZE-1:1]};
            end
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST) begin
                run_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/exec_unit.sv
// Execute stage: issue FSM, single-cycle ALU and registered write-back into
// the register file. MUL/DIV/MOD are delegated to iter_muldiv.
module exec_unit
    import exec_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    exec_unit_if.slave bus
);
    state_t              state_reg, state_next;
    opcode_t             op_reg;
    logic [REG_ADDR-1:0] dest_in_reg;
    logic [REG_SIZE-1:0] a_reg, b_reg;

    logic                write_en_reg, carry_reg, zero_reg, div_zero_reg, illegal_reg;
    logic [REG_ADDR-1:0] dest_reg;
    logic [REG_SIZE-1:0] write_val_reg;

    logic                issue, illegal_op, iter_go, iter_done;
    logic [REG_SIZE-1:0] iter_lo, iter_hi;
    logic [REG_SIZE:0]   add_full, sub_full;
    logic [REG_SIZE-1:0] wb_val;
    logic                wb_carry, wb_div_zero;

    assign issue      = (state_reg == ST_IDLE) && bus.start;
    assign illegal_op = (bus.opcode > OP_MOD);

    iter_muldiv u_iter (
        .clk  (clk),
        .rst  (rst),
        .go   (iter_go),
        .mode (bus.opcode != OP_MUL),
        .a    (bus.opA),
        .b    (bus.opB),
        .done (iter_done),
        .lo   (iter_lo),
        .hi   (iter_hi)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state decode; illegal opcodes never leave IDLE
    always_comb begin
        state_next = state_reg;
        iter_go    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start && !illegal_op) begin
                    if (is_iterative(bus.opcode, bus.opB)) begin
                        state_next = ST_ITER;
                        iter_go    = 1'b1;
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_ITER: if (iter_done) state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the issued operation; later start requests cannot disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg      <= OP_ADD;
            dest_in_reg <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
        end else if (issue && !illegal_op) begin
            op_reg      <= opcode_t'(bus.opcode);
            dest_in_reg <= bus.destIn;
            a_reg       <= bus.opA;
            b_reg       <= bus.opB;
        end
    end

    assign add_full    = {1'b0, a_reg} + {1'b0, b_reg};
    assign sub_full    = {1'b0, a_reg} - {1'b0, b_reg};
    assign wb_div_zero = ((op_reg == OP_DIV) || (op_reg == OP_MOD)) && (b_reg == '0);

    // Result and carry selection for the write-back cycle
    always_comb begin
        wb_val   = '0;
        wb_carry = 1'b0;
        case (op_reg)
            OP_ADD: {wb_carry, wb_val} = add_full;
            OP_SUB: {wb_carry, wb_val} = sub_full;
            OP_AND: wb_val = a_reg & b_reg;
            OP_OR:  wb_val = a_reg | b_reg;
            OP_XOR: wb_val = a_reg ^ b_reg;
            OP_SHL: wb_val = a_reg << b_reg[3:0];
            OP_SHR: wb_val = a_reg >> b_reg[3:0];
            OP_MOV: wb_val = b_reg;
            OP_MUL: begin
                wb_val   = iter_lo;
                wb_carry = (iter_hi != '0);
            end
            OP_DIV: wb_val = wb_div_zero ? '1 : iter_lo;
            OP_MOD: wb_val = wb_div_zero ? a_reg : iter_hi;
            default: wb_val = '0;
        endcase
    end

    // Registered write-back strobe, data and flags; held between write-backs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_en_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            dest_reg      <= '0;
            write_val_reg <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            div_zero_reg  <= 1'b0;
        end else begin
            write_en_reg <= (state_reg == ST_WB);
            illegal_reg  <= issue && illegal_op;
            if (state_reg == ST_WB) begin
                dest_reg      <= dest_in_reg;
                write_val_reg <= wb_val;
                carry_reg     <= wb_carry;
                zero_reg      <= (wb_val == '0);
                div_zero_reg  <= wb_div_zero;
            end
        end
    end

    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.writeEn  = write_en_reg;
    assign bus.dest     = dest_reg;
    assign bus.writeVal = write_val_reg;
    assign bus.carry    = carry_reg;
    assign bus.zero     = zero_reg;
    assign bus.divZero  = div_zero_reg;
    assign bus.illegal  = illegal_reg;
endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed test-plan vectors, start held
// while busy, illegal opcode, reset mid-operation and randomized operations.
module tb_exec_unit;
    import exec_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exec_unit_if bus();
    exec_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    // Observations from the latest run_op
    int          o_lat, o_we, o_busy, o_ill;
    logic [15:0] o_val;
    logic [2:0]  o_dest;
    logic        o_c, o_z, o_dz;

    // Architectural state expected after the most recent write-back
    logic [15:0] m_val = '0;
    logic [2:0]  m_dest = '0;
    logic        m_c = 1'b0, m_z = 1'b0, m_dz = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  d;
        logic [15:0] val;
        logic        c;
        logic        z;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs [7] = '{
        '{4'd0,  16'hFFFF, 16'h0001, 3'd3, 16'h0000, 1'b1, 1'b1, 1'b0, 1},
        '{4'd8,  16'h0123, 16'h0010, 3'd1, 16'h1230, 1'b0, 1'b0, 1'b0, 17},
        '{4'd8,  16'h8000, 16'h0002, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b0, 17},
        '{4'd9,  16'h03E8, 16'h0007, 3'd4, 16'h008E, 1'b0, 1'b0, 1'b0, 17},
        '{4'd10, 16'hBEEF, 16'h0100, 3'd5, 16'h00EF, 1'b0, 1'b0, 1'b0, 17},
        '{4'd10, 16'h1234, 16'h0000, 3'd6, 16'h1234, 1'b0, 1'b0, 1'b1, 1},
        '{4'd9,  16'h0005, 16'h0000, 3'd7, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1}
    };

    // Reference model: result from plain integer arithmetic on the opcode table
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] val, output logic c, output logic dz,
                         output int lat);
        longint ai, bi, r;
        ai = a; bi = b; r = 0;
        c = 1'b0; dz = 1'b0; lat = 1;
        case (op)
            4'd0:  begin r = ai + bi; c = (r > 65535); end
            4'd1:  begin r = ai - bi; c = (ai < bi); end
            4'd2:  r = ai & bi;
            4'd3:  r = ai | bi;
            4'd4:  r = ai ^ bi;
            4'd5:  r = ai << b[3:0];
            4'd6:  r = ai >> b[3:0];
            4'd7:  r = bi;
            4'd8:  begin r = ai * bi; c = (r > 65535); lat = 17; end
            4'd9:  if (bi == 0) begin r = 65535; dz = 1'b1; end
                   else begin r = ai / bi; lat = 17; end
            4'd10: if (bi == 0) begin r = ai; dz = 1'b1; end
                   else begin r = ai % bi; lat = 17; end
            default: r = 0;
        endcase
        val = r[15:0];
    endtask

    // Issue one operation and watch the outputs #1 after each rising edge.
    // With hold, start stays high (with other operands) until the write-back.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input bit hold);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.opA = a; bus.opB = b; bus.destIn = d;
        o_lat = -1; o_we = 0; o_busy = 0; o_ill = 0;
        o_val = '0; o_dest = '0; o_c = 1'b0; o_z = 1'b0; o_dz = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 0) begin
                if (hold) begin
                    bus.opA = ~a; bus.opB = b + 16'd3; bus.destIn = d + 3'd1;
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (bus.busy)    o_busy++;
            if (bus.illegal) o_ill++;
            if (bus.writeEn) begin
                o_we++;
                if (o_lat < 0) begin
                    o_lat = k; o_val = bus.writeVal; o_dest = bus.dest;
                    o_c = bus.carry; o_z = bus.zero; o_dz = bus.divZero;
                    bus.start = 1'b0;
                end
            end
            if (!hold && o_lat >= 0 && k >= o_lat + 2) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [25:0] obs;
        bus.start = 1'b0; bus.opcode = '0; bus.opA = '0; bus.opB = '0; bus.destIn = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {bus.busy, bus.writeEn, bus.dest, bus.writeVal, bus.carry, bus.zero,
               bus.divZero, bus.illegal};
        checks++;
        if (obs !== 26'd0) $display("FAIL reset_outputs: got %h want 0", obs);
        else passed++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.writeEn} !== 2'b00)
            $display("FAIL reset_release: busy/writeEn %b want 00", {bus.busy, bus.writeEn});
        else passed++;
    endtask

    task automatic test_directed();
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, 1'b0);
            checks++;
            if ({o_dest, o_val, o_c, o_z, o_dz} !==
                {vecs[i].d, vecs[i].val, vecs[i].c, vecs[i].z, vecs[i].dz})
                $display("FAIL directed%0d_result: dest=%0d val=%h c=%b z=%b dz=%b want dest=%0d val=%h c=%b z=%b dz=%b",
                         i, o_dest, o_val, o_c, o_z, o_dz, vecs[i].d, vecs[i].val,
                         vecs[i].c, vecs[i].z, vecs[i].dz);
            else passed++;
            checks++;
            if (o_lat !== vecs[i].lat || o_busy !== vecs[i].lat || o_we !== 1)
                $display("FAIL directed%0d_timing: lat=%0d busy=%0d we=%0d want lat=%0d busy=%0d we=1",
                         i, o_lat, o_busy, o_we, vecs[i].lat, vecs[i].lat);
            else passed++;
            m_val = vecs[i].val; m_dest = vecs[i].d;
            m_c = vecs[i].c; m_z = vecs[i].z; m_dz = vecs[i].dz;
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] a, b, e_val;
        logic        e_c, e_dz;
        int          e_lat;
        a = 16'($urandom); b = 16'($urandom);
        model(4'd8, a, b, e_val, e_c, e_dz, e_lat);
        run_op(4'd8, a, b, 3'd2, 1'b1);
        checks++;
        if ({o_dest, o_val, o_c, o_dz} !== {3'd2, e_val, e_c, e_dz})
            $display("FAIL hold_start_result: dest=%0d val=%h c=%b want dest=2 val=%h c=%b",
                     o_dest, o_val, o_c, e_val, e_c);
        else passed++;
        checks++;
        if (o_we !== 1 || o_lat !== 17)
            $display("FAIL hold_start_writes: we=%0d lat=%0d want we=1 lat=17", o_we, o_lat);
        else passed++;
        m_val = e_val; m_dest = 3'd2; m_c = e_c; m_z = (e_val == 16'd0); m_dz = e_dz;
    endtask

    task automatic test_illegal();
        run_op(4'hC, 16'h1111, 16'h2222, 3'd5, 1'b0);
        checks++;
        if (o_ill !== 1 || o_we !== 0 || o_busy !== 0)
            $display("FAIL illegal_pulse: ill=%0d we=%0d busy=%0d want 1 0 0", o_ill, o_we, o_busy);
        else passed++;
        checks++;
        if ({bus.dest, bus.writeVal, bus.carry, bus.zero, bus.divZero} !==
            {m_dest, m_val, m_c, m_z, m_dz})
            $display("FAIL illegal_hold: dest=%0d val=%h c=%b z=%b dz=%b want %0d %h %b %b %b",
                     bus.dest, bus.writeVal, bus.carry, bus.zero, bus.divZero,
                     m_dest, m_val, m_c, m_z, m_dz);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int late_we;
        run_op(4'd0, 16'h1111, 16'h2222, 3'd5, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 4'd8; bus.opA = 16'h00FF; bus.opB = 16'h0101; bus.destIn = 3'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.writeEn, bus.dest, bus.writeVal, bus.carry, bus.zero,
             bus.divZero, bus.illegal} !== 26'd0)
            $display("FAIL midop_reset: busy=%b we=%b dest=%0d val=%h flags=%b%b%b%b want all 0",
                     bus.busy, bus.writeEn, bus.dest, bus.writeVal, bus.carry, bus.zero,
                     bus.divZero, bus.illegal);
        else passed++;
        @(negedge clk); rst = 1'b1;
        late_we = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.writeEn) late_we++;
        end
        checks++;
        if (late_we !== 0) $display("FAIL midop_no_wb: writes=%0d want 0", late_we);
        else passed++;
        run_op(4'd1, 16'd5, 16'd7, 3'd1, 1'b0);
        checks++;
        if ({o_val, o_c, o_z, o_lat} !== {16'hFFFE, 1'b1, 1'b0, 32'sd1})
            $display("FAIL post_reset_sub: val=%h c=%b z=%b lat=%0d want fffe 1 0 1",
                     o_val, o_c, o_z, o_lat);
        else passed++;
        m_val = 16'hFFFE; m_dest = 3'd1; m_c = 1'b1; m_z = 1'b0; m_dz = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] a, b, e_val;
        logic [2:0]  d;
        logic        e_c, e_dz;
        int          e_lat;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 10));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            d  = 3'($urandom);
            model(op, a, b, e_val, e_c, e_dz, e_lat);
            run_op(op, a, b, d, 1'b0);
            checks++;
            if ({o_dest, o_val, o_c, o_z, o_dz} !== {d, e_val, e_c, (e_val == 16'd0), e_dz})
                $display("FAIL random%0d_op%0d: a=%h b=%h dest=%0d val=%h c=%b z=%b dz=%b want dest=%0d val=%h c=%b dz=%b",
                         n, op, a, b, o_dest, o_val, o_c, o_z, o_dz, d, e_val, e_c, e_dz);
            else passed++;
            checks++;
            if (o_lat !== e_lat || o_busy !== e_lat || o_we !== 1)
                $display("FAIL random%0d_timing: lat=%0d busy=%0d we=%0d want lat=%0d busy=%0d we=1",
                         n, o_lat, o_busy, o_we, e_lat, e_lat);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_illegal();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
